// File: rtl/seq_cla_adder32.sv
// Multi-cycle 32-bit adder/subtractor: sums one STEP-bit slice per clock using
// chained 4-bit carry-lookahead groups, with a valid/ready handshake on each side.
module seq_cla_adder32 #(
    parameter int WIDTH = 32,
    parameter int STEP  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = WIDTH / STEP;
    localparam int NGROUP = STEP / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [STEP-1:0]  w_sa;
    logic [STEP-1:0]  w_sb;
    logic [STEP-1:0]  w_slice_sum;
    logic             w_slice_cout;
    logic             w_c_msb;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_last;

    assign w_sa   = r_a[r_idx*STEP +: STEP];
    assign w_sb   = r_b[r_idx*STEP +: STEP];
    assign w_last = (r_idx == IDXW'(NSLICE - 1));

    // Slice adder: lookahead inside each 4-bit group, group P/G ripple between groups.
    always_comb begin
        logic [3:0] p;
        logic [3:0] gn;
        logic [3:0] c;
        logic       c_grp;
        logic       grp_g;
        logic       grp_p;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        p           = '0;
        gn          = '0;
        c           = '0;
        grp_g       = 1'b0;
        grp_p       = 1'b0;
        c_grp       = r_carry;
        w_slice_sum = '0;
        w_c_msb     = 1'b0;
        for (int g = 0; g < NGROUP; g++) begin
            p    = w_sa[g*4 +: 4] ^ w_sb[g*4 +: 4];
            gn   = w_sa[g*4 +: 4] & w_sb[g*4 +: 4];
            c[0] = c_grp;
            c[1] = gn[0] | (p[0] & c_grp);
            c[2] = gn[1] | (p[1] & gn[0]) | (p[1] & p[0] & c_grp);
            c[3] = gn[2] | (p[2] & gn[1]) | (p[2] & p[1] & gn[0]) | (p[2] & p[1] & p[0] & c_grp);
            w_slice_sum[g*4 +: 4] = p ^ c;
            grp_g = gn[3] | (p[3] & gn[2]) | (p[3] & p[2] & gn[1]) | (p[3] & p[2] & p[1] & gn[0]);
            grp_p = &p;
            if (g == NGROUP - 1) w_c_msb = c[3];
            c_grp = grp_g | (grp_p & c_grp);
        end
        w_slice_cout = c_grp;
        w_sum_next   = r_sum;
        w_sum_next[r_idx*STEP +: STEP] = w_slice_sum;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= op_sub ? ~b : b;
                        r_carry    <= op_sub ? 1'b1 : cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_slice_cout;
                    if (w_last) begin
                        r_cout      <= w_slice_cout;
                        r_ovf       <= w_c_msb ^ w_slice_cout;
                        r_zero      <= (w_sum_next == '0);
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_seq_cla_adder32.sv
// Directed bench for seq_cla_adder32: hand-computed vectors, latency, handshake,
// backpressure and mid-operation reset.
module tb_seq_cla_adder32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_cla_adder32 #(.WIDTH(32), .STEP(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer an operand set, confirm acceptance and 4-edge latency, check the result in DONE.
    task automatic start_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                            input logic icin, input logic isub,
                            input logic [31:0] e_sum, input logic e_cout,
                            input logic e_ovf, input logic e_zero);
        int lat;
        a        = ia;
        b        = ib;
        cin      = icin;
        op_sub   = isub;
        in_valid = 1'b1;
        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check({tag, ".in_ready_run"}, 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            a         = $urandom;
            b         = $urandom;
            cin       = ~cin;
            out_ready = 1'b1;
            tick();
            lat++;
        end
        out_ready = 1'b0;
        check({tag, ".latency"}, 64'(lat), 64'd4);
        check({tag, ".sum"},  64'(sum),  64'(e_sum));
        check({tag, ".cout"}, 64'(cout), 64'(e_cout));
        check({tag, ".ovf"},  64'(ovf),  64'(e_ovf));
        check({tag, ".zero"}, 64'(zero), 64'(e_zero));
    endtask

    task automatic release_op(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".out_valid_clr"}, 64'(out_valid), 64'd0);
        check({tag, ".in_ready_back"}, 64'(in_ready),  64'd1);
    endtask

    initial begin
        logic [31:0] held;
        int          seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op_sub    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset.in_ready",  64'(in_ready),  64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.sum",       64'(sum),       64'd0);
        check("reset.flags",     64'({cout, ovf, zero}), 64'd0);

        start_op("wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        release_op("wrap");
        start_op("posovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        release_op("posovf");
        start_op("sub5_7", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        release_op("sub5_7");
        start_op("sub7_5", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        release_op("sub7_5");
        start_op("xslice", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
        release_op("xslice");
        start_op("cinonly", 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        release_op("cinonly");
        start_op("negovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        release_op("negovf");
        start_op("mixed",  32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0);

        // Backpressure: result held while new operands are offered and ignored.
        held = sum;
        for (int i = 0; i < 3; i++) begin
            a        = 32'h1111_1111 * (i + 1);
            b        = 32'h0000_0002;
            cin      = 1'b0;
            op_sub   = 1'b0;
            in_valid = 1'b1;
            tick();
            check("bp.out_valid", 64'(out_valid), 64'd1);
            check("bp.in_ready",  64'(in_ready),  64'd0);
            check("bp.sum",       64'(sum),       64'(held));
            check("bp.flags",     64'({cout, ovf, zero}), 64'd0);
        end
        in_valid = 1'b0;
        release_op("bp");
        start_op("bp_next", 32'h3333_3333, 32'h0000_0002, 1'b0, 1'b0, 32'h3333_3335, 1'b0, 1'b0, 1'b0);
        release_op("bp_next");

        // Reset during the second RUN cycle discards the operation.
        a        = 32'hFFFF_FFFF;
        b        = 32'h0000_0001;
        cin      = 1'b0;
        op_sub   = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_run.in_ready",  64'(in_ready),  64'd1);
        check("rst_run.out_valid", 64'(out_valid), 64'd0);
        check("rst_run.sum",       64'(sum),       64'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("rst_run.no_result", 64'(seen), 64'd0);

        // Reset while in DONE clears the held result.
        start_op("pre_rst", 32'h0000_00F0, 32'h0000_0010, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_done.out_valid", 64'(out_valid), 64'd0);
        check("rst_done.in_ready",  64'(in_ready),  64'd1);
        check("rst_done.sum",       64'(sum),       64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_cla_adder32.md
SEQ_CLA_ADDER32 -- requirements
Module: seq_cla_adder32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (multiple of STEP).
REQ-002 SHALL have parameter STEP, default 8, bits summed per cycle (multiple of 4).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand set offered.
REQ-007 in_ready  output  1  block accepts operands.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in for add; ignored for subtract.
REQ-011 op_sub  input  1  0 = A+B+cin, 1 = A-B.
REQ-012 out_valid  output  1  result held and valid.
REQ-013 out_ready  input  1  consumer takes result.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  carry out of MSB (for subtract, 1 = no borrow).
REQ-016 ovf  output  1  two's-complement overflow.
REQ-017 zero  output  1  sum equals 0.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE.
REQ-019 IDLE: in_ready=1, out_valid=0; on in_valid=1, latch a, b (or ~b if op_sub), carry register = cin (1 if op_sub), slice index = 0, then go to RUN.
REQ-020 RUN: each cycle, add latched bits [idx*STEP +: STEP] plus the carry register using 4-bit carry-lookahead groups (group P/G chained within the slice), write the result into sum bits, register carry-out, idx+1.
REQ-021 After slice WIDTH/STEP-1 is written, go to DONE; cout = final carry; ovf = carry into MSB XOR carry out of MSB; zero = (full sum == 0).
REQ-022 DONE: out_valid=1; sum, cout, ovf, zero held stable; on out_ready=1, go to IDLE.
REQ-023 Latency: out_valid SHALL rise exactly WIDTH/STEP rising edges after the accepting edge (4 at defaults).
REQ-024 in_ready SHALL be 0 in RUN and DONE; in_valid during those states is ignored and no operand is latched.
REQ-025 out_valid deasserts on the edge where out_ready=1 in DONE; in_ready returns 1 the same edge (no accept while out_valid=1; minimum 6-cycle issue interval at defaults).
REQ-026 Latched operands SHALL NOT change after acceptance; input changes during RUN do not affect the result.
REQ-027 out_ready in IDLE or RUN SHALL have no effect.
REQ-028 sum bits of slices not yet computed in RUN are don't-care externally (out_valid=0).

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, zero=0, carry/index registers 0, in any state including mid-RUN and DONE.
REQ-030 An operation interrupted by reset SHALL be discarded and never produce out_valid.

Verification
REQ-031 add a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0, zero=1, out_valid 4 edges after accept.
REQ-032 add a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, cout=0, ovf=1, zero=0.
REQ-033 op_sub=1, a=5, b=7, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0; a=7, b=5 -> sum=2, cout=1.
REQ-034 cross-slice carry: a=0x00FFFFFF, b=0x00000001, cin=0 -> sum=0x01000000; a=0, b=0, cin=1 -> sum=0x00000001, zero=0.
REQ-035 backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands -> outputs unchanged, in_ready=0, new operands not taken; then out_ready=1 -> IDLE, next operands accepted.
REQ-036 assert rst during 2nd RUN cycle -> next edge in_ready=1, out_valid=0, sum=0; the aborted result never appears.
